fetch_sequencer: RTL and testbench

- Drives the instruction-fetch stage of the 5-stage pipeline.
- Owns the PC and runs the req/ack handshake to instruction memory.
- Sequences the IF/ID pipeline register through a write-enable pulse and a flush pulse.
- Honours stall requests from the hazard unit and redirect requests from branch/jump resolution in EX.

---
 rtl/fetch_sequencer.sv | 159 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs the req/ack handshake to
// instruction memory and drives the IF/ID write/flush pulses.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic [31:0] pc
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [31:0] drain_addr;
    logic [31:0] drain_addr_next;
    logic [31:0] hold_instr;
    logic [31:0] hold_instr_next;
    logic [31:0] hold_npc;
    logic [31:0] hold_npc_next;
    logic [31:0] instr_next;
    logic [31:0] npc_next;
    logic        we_next;
    logic        flush_next;
    logic        req_next;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target = {redirect_pc[31:2], 2'b00};
    assign pc_inc = pc + STEP;

    // While draining a stale request the bus must keep the old address even
    // though pc already holds the redirect target.
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        drain_addr_next = drain_addr;
        hold_instr_next = hold_instr;
        hold_npc_next   = hold_npc;
        instr_next      = ifid_instr;
        npc_next        = ifid_npc;
        we_next         = 1'b0;
        flush_next      = 1'b0;

        case (state)
            IDLE: begin
                state_next = FETCH;
                if (redirect) begin
                    pc_next = target;
                end
            end

            FETCH: begin
                if (redirect) begin
                    pc_next         = target;
                    flush_next      = 1'b1;
                    hold_instr_next = '0;
                    hold_npc_next   = '0;
                    if (!imem_ack) begin
                        state_next      = DRAIN;
                        drain_addr_next = pc;
                    end
                end else if (imem_ack) begin
                    pc_next = pc_inc;
                    if (stall) begin
                        hold_instr_next = imem_rdata;
                        hold_npc_next   = pc_inc;
                        state_next      = HOLD;
                    end else begin
                        we_next    = 1'b1;
                        instr_next = imem_rdata;
                        npc_next   = pc_inc;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_next         = target;
                    flush_next      = 1'b1;
                    hold_instr_next = '0;
                    hold_npc_next   = '0;
                    state_next      = FETCH;
                end else if (!stall) begin
                    we_next    = 1'b1;
                    instr_next = hold_instr;
                    npc_next   = hold_npc;
                    state_next = FETCH;
                end
            end

            DRAIN: begin
                // An ack here retires the stale request; its data is dropped.
                if (redirect) begin
                    pc_next    = target;
                    flush_next = 1'b1;
                end
                if (imem_ack) begin
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_next = (state_next == FETCH) || (state_next == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= '0;
            hold_instr <= '0;
            hold_npc   <= '0;
            imem_req   <= 1'b0;
            ifid_we    <= 1'b0;
            ifid_flush <= 1'b0;
            ifid_instr <= '0;
            ifid_npc   <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            drain_addr <= drain_addr_next;
            hold_instr <= hold_instr_next;
            hold_npc   <= hold_npc_next;
            imem_req   <= req_next;
            ifid_we    <= we_next;
            ifid_flush <= flush_next;
            ifid_instr <= instr_next;
            ifid_npc   <= npc_next;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random
// traffic, all compared against a transaction-level fetch model.
module tb_fetch_sequencer;

    localparam logic [31:0] ALT_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        a_req, a_we, a_flush;
    logic [31:0] a_addr, a_instr, a_npc, a_pc;
    logic        b_req, b_we, b_flush;
    logic [31:0] b_addr, b_instr, b_npc, b_pc;

    logic        sel;
    logic        o_req, o_we, o_flush;
    logic [31:0] o_addr, o_instr, o_npc, o_pc;

    int errors = 0;
    int checks = 0;

    // Model: program counter, whether a stale request is being drained,
    // and a queue of fetched-but-stalled instructions.
    bit          m_started;
    logic [31:0] m_pc;
    bit          m_stale;
    logic [31:0] m_stale_addr;
    logic [63:0] m_held[$];
    logic        m_we, m_flush;
    logic [31:0] m_instr, m_npc;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(a_req), .imem_addr(a_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_we(a_we), .ifid_flush(a_flush), .ifid_instr(a_instr), .ifid_npc(a_npc), .pc(a_pc)
    );

    fetch_sequencer #(.RESET_PC(ALT_PC), .PC_STEP(4)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_we(b_we), .ifid_flush(b_flush), .ifid_instr(b_instr), .ifid_npc(b_npc), .pc(b_pc)
    );

    assign o_req   = sel ? b_req   : a_req;
    assign o_addr  = sel ? b_addr  : a_addr;
    assign o_we    = sel ? b_we    : a_we;
    assign o_flush = sel ? b_flush : a_flush;
    assign o_instr = sel ? b_instr : a_instr;
    assign o_npc   = sel ? b_npc   : a_npc;
    assign o_pc    = sel ? b_pc    : a_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    function automatic bit exp_req();
        return m_started && (m_held.size() == 0);
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_stale ? m_stale_addr : m_pc;
    endfunction

    function automatic logic [130:0] obs_vec();
        return {o_req, o_addr, o_pc, o_we, o_flush, o_instr, o_npc};
    endfunction

    function automatic logic [130:0] exp_vec();
        return {exp_req(), exp_addr(), m_pc, m_we, m_flush, m_instr, m_npc};
    endfunction

    task automatic model_reset();
        m_started = 0;
        m_pc      = sel ? ALT_PC : 32'h0;
        m_stale   = 0;
        m_held.delete();
        m_we      = 0;
        m_flush   = 0;
        m_instr   = '0;
        m_npc     = '0;
    endtask

    task automatic model_edge(input logic a, input logic [31:0] rd, input logic s,
                              input logic r, input logic [31:0] rp);
        logic [31:0] tgt;
        tgt     = rp & ~32'h3;
        m_we    = 0;
        m_flush = 0;
        if (!m_started) begin
            m_started = 1;
            if (r) m_pc = tgt;
        end else if (r) begin
            m_flush = 1;
            if (m_stale) begin
                if (a) m_stale = 0;
            end else if (m_held.size() == 0 && !a) begin
                m_stale      = 1;
                m_stale_addr = m_pc;
            end
            m_held.delete();
            m_pc = tgt;
        end else if (m_stale) begin
            if (a) m_stale = 0;
        end else if (m_held.size() != 0) begin
            if (!s) begin
                {m_instr, m_npc} = m_held.pop_front();
                m_we = 1;
            end
        end else if (a) begin
            if (s) m_held.push_back({rd, m_pc + 32'd4});
            else begin
                m_instr = rd;
                m_npc   = m_pc + 32'd4;
                m_we    = 1;
            end
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic cycle(input logic a, input logic s, input logic r,
                         input logic [31:0] rp, input logic [31:0] rd);
        imem_ack    = a;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        imem_rdata  = rd;
        @(posedge clk);
        model_edge(a, rd, s, r, rp);
        #1;
        imem_ack = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic assert_reset();
        imem_ack = 0; stall = 0; redirect = 0; redirect_pc = '0; imem_rdata = '0;
        rst = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0;
        assert_reset();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_vec got=%h exp=%h", obs_vec(), exp_vec());
        end
        release_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
        checks++;
        if (o_we !== 1'b0 || o_req !== 1'b1) begin
            errors++; $display("FAIL idle_late_ack we=%b req=%b exp we=0 req=1", o_we, o_req);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL idle_vec got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_streaming();
        assert_reset();
        release_reset();
        for (int i = 1; i <= 10; i++) begin
            cycle(exp_req(), 1'b0, 1'b0, 32'h0, word(exp_addr()));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL stream_vec cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (i <= 4) begin
                checks++;
                if (o_addr !== 32'((i - 1) * 4)) begin
                    errors++; $display("FAIL stream_addr cyc=%0d got=%h exp=%h", i, o_addr, (i - 1) * 4);
                end
            end
            if (i >= 2) begin
                checks++;
                if (o_we !== 1'b1) begin
                    errors++; $display("FAIL stream_we cyc=%0d got=%b exp=1", i, o_we);
                end
            end
            if (i >= 2 && i <= 5) begin
                checks++;
                if (o_npc !== 32'((i - 1) * 4)) begin
                    errors++; $display("FAIL stream_npc cyc=%0d got=%h exp=%h", i, o_npc, (i - 1) * 4);
                end
            end
        end
    endtask

    task automatic test_wait_states();
        int pulses = 0;
        for (int k = 0; k < 6; k++) begin
            for (int w = 0; w < 3; w++) begin
                cycle(w == 2, 1'b0, 1'b0, 32'h0, word(exp_addr()));
                if (o_we) pulses++;
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL wait_vec k=%0d w=%0d got=%h exp=%h", k, w, obs_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (pulses != 6) begin
            errors++; $display("FAIL wait_pulses got=%0d exp=6", pulses);
        end
    endtask

    task automatic test_stall();
        assert_reset();
        release_reset();
        for (int i = 1; i <= 10; i++) begin
            cycle(exp_req(), (i >= 4 && i <= 6), 1'b0, 32'h0, word(exp_addr()));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL stall_vec cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (i >= 4 && i <= 6) begin
                checks++;
                if (o_we !== 1'b0) begin
                    errors++; $display("FAIL stall_we cyc=%0d got=%b exp=0", i, o_we);
                end
            end
            if (i == 7) begin
                checks++;
                if (o_we !== 1'b1 || o_instr !== word(32'h8) || o_npc !== 32'hC || o_addr !== 32'hC) begin
                    errors++;
                    $display("FAIL stall_release we=%b instr=%h npc=%h addr=%h exp 1 %h c c",
                             o_we, o_instr, o_npc, o_addr, word(32'h8));
                end
            end
        end
    endtask

    task automatic test_redirect_drain();
        assert_reset();
        release_reset();
        for (int i = 1; i <= 10; i++) begin
            cycle(exp_req() && !(i == 6 || i == 7), 1'b0, (i == 6), 32'h100, word(exp_addr()));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL drain_vec cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (i == 6) begin
                checks++;
                if (o_flush !== 1'b1 || o_addr !== 32'h10 || o_pc !== 32'h100) begin
                    errors++; $display("FAIL drain_start flush=%b addr=%h pc=%h exp 1 10 100", o_flush, o_addr, o_pc);
                end
            end
            if (i == 7) begin
                checks++;
                if (o_flush !== 1'b0 || o_addr !== 32'h10) begin
                    errors++; $display("FAIL drain_hold flush=%b addr=%h exp 0 10", o_flush, o_addr);
                end
            end
            if (i == 8) begin
                checks++;
                if (o_we !== 1'b0 || o_addr !== 32'h100) begin
                    errors++; $display("FAIL drain_done we=%b addr=%h exp 0 100", o_we, o_addr);
                end
            end
            if (i == 9) begin
                checks++;
                if (o_we !== 1'b1 || o_npc !== 32'h104 || o_instr !== word(32'h100)) begin
                    errors++; $display("FAIL drain_first we=%b npc=%h instr=%h exp 1 104 %h", o_we, o_npc, o_instr, word(32'h100));
                end
            end
        end
    endtask

    task automatic test_redirect_stall();
        assert_reset();
        release_reset();
        for (int i = 1; i <= 10; i++) begin
            cycle(exp_req(), (i >= 4 && i <= 7), (i == 4), 32'h203, word(exp_addr()));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rs_vec cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (i == 4) begin
                checks++;
                if (o_flush !== 1'b1 || o_we !== 1'b0 || o_pc !== 32'h200) begin
                    errors++; $display("FAIL rs_flush flush=%b we=%b pc=%h exp 1 0 200", o_flush, o_we, o_pc);
                end
            end
            if (i >= 5 && i <= 7) begin
                checks++;
                if (o_we !== 1'b0) begin
                    errors++; $display("FAIL rs_held cyc=%0d we=%b exp=0", i, o_we);
                end
            end
            if (i == 8) begin
                checks++;
                if (o_we !== 1'b1 || o_instr !== word(32'h200) || o_npc !== 32'h204) begin
                    errors++; $display("FAIL rs_release we=%b instr=%h npc=%h exp 1 %h 204", o_we, o_instr, o_npc, word(32'h200));
                end
            end
        end
    endtask

    task automatic test_random();
        assert_reset();
        release_reset();
        for (int i = 0; i < 600; i++) begin
            logic a, s, r;
            s = ($urandom % 4) == 0;
            r = ($urandom % 12) == 0;
            a = exp_req() && ($urandom % 2 == 0);
            cycle(a, s, r, $urandom, $urandom);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rand_vec cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (o_we === 1'b1 && o_flush === 1'b1) begin
                errors++; $display("FAIL rand_we_flush cyc=%0d got we=1 flush=1 exp not both", i);
            end
        end
    endtask

    task automatic test_wrap();
        sel = 1;
        assert_reset();
        release_reset();
        for (int i = 1; i <= 6; i++) begin
            cycle(exp_req(), 1'b0, 1'b0, 32'h0, word(exp_addr()));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL wrap_vec cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (i <= 4) begin
                checks++;
                if (o_addr !== ALT_PC + 32'((i - 1) * 4)) begin
                    errors++; $display("FAIL wrap_addr cyc=%0d got=%h exp=%h", i, o_addr, ALT_PC + 32'((i - 1) * 4));
                end
            end
            if (i == 3) begin
                checks++;
                if (o_npc !== 32'h0) begin
                    errors++; $display("FAIL wrap_npc got=%h exp=0", o_npc);
                end
            end
        end
        assert_reset();
        checks++;
        if (o_req !== 1'b0 || o_we !== 1'b0 || o_flush !== 1'b0 || o_instr !== 32'h0 ||
            o_npc !== 32'h0 || o_pc !== ALT_PC) begin
            errors++;
            $display("FAIL midreq_reset req=%b we=%b flush=%b instr=%h npc=%h pc=%h exp 0 0 0 0 0 %h",
                     o_req, o_we, o_flush, o_instr, o_npc, o_pc, ALT_PC);
        end
        release_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL wrap_idle_vec got=%h exp=%h", obs_vec(), exp_vec());
        end
        sel = 0;
    endtask

    initial begin
        sel = 0;
        rst = 1'b1;
        imem_ack = 0; stall = 0; redirect = 0; redirect_pc = '0; imem_rdata = '0;
        test_reset();
        test_streaming();
        test_wait_states();
        test_stall();
        test_redirect_drain();
        test_redirect_stall();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
